// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Build with UART_TX_PARITY_EN defined to add an even-parity bit (11-bit frame).
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the serializer: wrapping pointers plus a fill counter.
// Full and empty come from the counter so a wrapped pointer pair is never ambiguous.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [DATA_BITS-1:0]   wr_data_i,
  input  logic                   rd_en_i,
  output logic [DATA_BITS-1:0]   rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_wr;
  logic                 do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write while full is dropped even if a pop happens in the same cycle.
  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Queued UART transmitter: byte FIFO plus start/data/stop serializer FSM.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        UART_CLK,
  input  logic                        reset,
  input  logic                        write_req,
  input  logic [7:0]                  write_data,
  output logic                        tx,
  output logic                        busy,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow
);

  localparam int                 CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         LAST_BIT   = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 pop;
  logic                 bit_done;
  logic [DATA_BITS-1:0] head_byte;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (UART_CLK),
    .reset_i  (reset),
    .wr_en_i  (write_req),
    .wr_data_i(write_data),
    .rd_en_i  (pop),
    .rd_data_o(head_byte),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (fill_level)
  );

  assign bit_done   = (cnt_q == '0);
  assign overflow_d = overflow_q | (write_req & full);
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = overflow_q;

  // NOTE: every next-state signal gets its hold value first so no path through the case leaves a latch.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != ST_IDLE) cnt_d = bit_done ? CNT_RELOAD : cnt_q - CNT_W'(1);

    case (state_q)
      ST_IDLE:  if (!empty) pop = 1'b1;
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase

    // Loading the next byte drops the line low on the same edge: no idle gap between frames.
    if (pop) begin
      state_d = ST_START;
      tx_d    = 1'b0;
      shift_d = head_byte;
      cnt_d   = CNT_RELOAD;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head_byte;
`endif
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= IDLE_LEVEL;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: queue/frame model compared every cycle,
// plus directed literal checks. Honours UART_TX_PARITY_EN like the design.
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CYC = 44;
`else
  localparam int FRAME_CYC = 40;
`endif

  logic          UART_CLK = 1'b0;
  logic          reset;
  logic          write_req;
  logic [7:0]    write_data;
  logic          tx;
  logic          busy;
  logic          full;
  logic          empty;
  logic [FW-1:0] fill_level;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .UART_CLK  (UART_CLK),
    .reset     (reset),
    .write_req (write_req),
    .write_data(write_data),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .empty     (empty),
    .fill_level(fill_level),
    .overflow  (overflow)
  );

  always #5 UART_CLK = ~UART_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus a per-cycle list of line levels still to be sent.
  logic [7:0] mq[$];
  logic       line[$];
  logic       m_ovf = 1'b0;
  bit         model_on = 1'b0;
  int         m_pre;
  logic [7:0] m_byte;

  function automatic void append_frame(input logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int c = 0; c < CPB; c++) line.push_back(bits[k]);
  endfunction

  always @(posedge UART_CLK) begin
    if (reset) begin
      mq.delete();
      line.delete();
      m_ovf    = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_pre = mq.size();
      if (line.size() > 0) void'(line.pop_front());
      if (line.size() == 0 && m_pre > 0) begin
        m_byte = mq.pop_front();
        append_frame(m_byte);
      end
      if (write_req) begin
        if (m_pre == DEPTH) m_ovf = 1'b1;
        else mq.push_back(write_data);
      end
    end
  end

  always @(negedge UART_CLK) begin
    if (model_on) begin
      check("tx", tx, (line.size() > 0) ? line[0] : 1'b1);
      check("busy", busy, line.size() > 0);
      check("fill_level", fill_level, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic cyc(input logic wr, input logic [7:0] d, input logic rst);
    write_req  = wr;
    write_data = d;
    reset      = rst;
    @(posedge UART_CLK);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tx"}, tx, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_fill"}, fill_level, 0);
    check({tag, "_ovf"}, overflow, 1'b0);
  endtask

  // One byte from idle: capture mid-bit line levels and count busy cycles.
  task automatic frame_test(input logic [7:0] d, input logic [10:0] exp_bits, input string tag);
    logic [10:0] got;
    int          busy_cnt;
    got      = '0;
    busy_cnt = 0;
    cyc(1'b1, d, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c % CPB == 1) got[c / CPB] = tx;
      if (busy) busy_cnt++;
      cyc(1'b0, 8'h00, 1'b0);
    end
    check({tag, "_bits"}, got, exp_bits);
    check({tag, "_busy_cycles"}, busy_cnt, FRAME_CYC);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_empty_after"}, empty, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int dens;
    write_req  = 1'b0;
    write_data = 8'h00;
    reset      = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    check_reset_state("reset");

`ifdef UART_TX_PARITY_EN
    frame_test(8'hA5, 11'h54A, "a5");
    frame_test(8'h07, 11'h60E, "x07");
`else
    frame_test(8'hA5, 11'h34A, "a5");
    frame_test(8'h07, 11'h20E, "x07");
`endif

    // Back-to-back bytes: busy must stay high across both frames.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      cyc(1'b0, 8'h00, 1'b0);
    end
    check("b2b_busy_cycles", cnt, 2 * FRAME_CYC);
    check("b2b_empty", empty, 1'b1);

    // Fill: first write pops at once, the next 16 fill the queue, one more is dropped.
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i + 8'h40), 1'b0);
    check("fill_level16", fill_level, 16);
    check("full_set", full, 1'b1);
    check("ovf_still_clear", overflow, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0);
    check("ovf_set", overflow, 1'b1);
    check("fill_after_drop", fill_level, 16);
    cyc(1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    check_reset_state("reset_full");

    // Write coinciding with the pop at the end of the first STOP bit.
    cyc(1'b1, 8'h81, 1'b0);
    cyc(1'b1, 8'h42, 1'b0);
    cyc(1'b1, 8'h24, 1'b0);
    cyc(1'b1, 8'h18, 1'b0);
    for (int i = 0; i < FRAME_CYC - 3; i++) cyc(1'b0, 8'h00, 1'b0);
    check("sim_fill_before", fill_level, 3);
    cyc(1'b1, 8'h3C, 1'b0);
    check("sim_fill_after", fill_level, 3);
    check("sim_busy", busy, 1'b1);
    cnt = 0;
    while ((busy || !empty) && cnt < 6 * FRAME_CYC) begin
      cnt++;
      cyc(1'b0, 8'h00, 1'b0);
    end
    check("sim_drained", busy, 1'b0);

    // Reset during data bit 4 of 0x55 with more bytes queued.
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b0);
    check("mid_busy", busy, 1'b1);
    check("mid_fill", fill_level, 2);
    cyc(1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    check_reset_state("reset_mid");
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy || !tx) cnt++;
      cyc(1'b0, 8'h00, 1'b0);
    end
    check("no_frame_after_reset", cnt, 0);

    // Random traffic with varying density and rare resets.
    dens = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) dens = $urandom_range(0, 100);
      cyc(($urandom_range(0, 99) < dens), 8'($urandom), ($urandom_range(0, 1499) == 0));
    end
    reset = 1'b0;
    cnt = 0;
    while ((busy || !empty) && cnt < (DEPTH + 2) * FRAME_CYC) begin
      cnt++;
      cyc(1'b0, 8'h00, 1'b0);
    end
    check("final_drain_busy", busy, 1'b0);
    check("final_drain_empty", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
